regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of two, >= 2).
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Derived constant AW = log2(NREG), register address width.
REQ-005 One clock, the rising edge only; reset is asynchronous and active-low.
REQ-006 clock  in  1  system clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 rd_addr  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-009 rd_data  out  NRD*XLEN  packed read data, combinational.
REQ-010 rd_busy  out  NRD  per read port: addressed register has a pending write.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 wr_addr  in  AW  writeback register.
REQ-013 wr_data  in  XLEN  writeback value.
REQ-014 sb_set  in  1  issue strobe: mark sb_addr pending.
REQ-015 sb_addr  in  AW  register being marked pending.
REQ-016 flush  in  1  synchronous clear of all pending marks and of err.
REQ-017 pend_cnt  out  AW+1  number of registers currently marked pending.
REQ-018 err  out  1  sticky flag for WAW issue or writeback to a non-pending register.

Function
REQ-019 Register 0 reads as zero; writes to it and sb_set to it are ignored, and it is never pending.
REQ-020 With wr_en=1 and wr_addr!=0, the register takes wr_data at the rising edge.
REQ-021 Reads are bypassed: if wr_en=1 and rd_addr[k]==wr_addr!=0, rd_data[k]=wr_data in the same cycle.
REQ-022 rd_busy[k] = pending[rd_addr[k]] AND NOT (wr_en AND wr_addr==rd_addr[k]), so a same-cycle writeback unblocks the read.
REQ-023 At the edge, wr_en clears pending[wr_addr]; sb_set sets pending[sb_addr].
REQ-024 When the same register gets set and clear in one cycle, set wins and the bit stays 1.
REQ-025 At the edge, pend_cnt is updated by +1 for a 0->1 transition, -1 for a 1->0 transition, and 0 otherwise; it equals the popcount of the pending bits at all times.
REQ-026 err is set at the edge when sb_set targets an already-pending register that wr_en does not clear in the same cycle.
REQ-027 err is also set at the edge when wr_en targets a non-pending register (addr!=0) that sb_set does not target in the same cycle.
REQ-028 Once set, err holds until flush or reset.
REQ-029 When flush=1: all pending bits clear, pend_cnt becomes 0, and err clears.
REQ-030 During flush, a same-cycle register write still commits, and a same-cycle sb_set is ignored.
REQ-031 Register contents are unaffected by flush.

Reset
REQ-032 On reset_n low, immediately and asynchronously: all registers 0, all pending bits 0, pend_cnt 0, err 0.
REQ-033 Assertion of reset_n mid-operation aborts any pending marks with no residual state.
REQ-034 The first write after reset_n rises takes effect at the first rising edge following deassertion.

Structure
REQ-035 XLEN, NREG, and NRD defaults live in the shared core package alongside the other core-wide constants.
REQ-036 The pending-bit array, pend_cnt, and err logic form one sub-module, regfile_scoreboard; the storage array and the bypass logic stay in regfile_sb.

Verification
REQ-037 Reset, then write x5=0xDEADBEEF; next cycle read rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF.
REQ-038 wr_en, wr_addr=0, wr_data=0xFFFFFFFF -> read x0 = 0; sb_set to x0 -> pend_cnt stays 0.
REQ-039 Same cycle: wr_en x7=0x12345678 and rd_addr[1]=7 -> rd_data[1]=0x12345678 combinationally.
REQ-040 sb_set x3 -> pend_cnt=1 and rd_busy=1 on x3. Then wr_en x3 and sb_set x3 in the same cycle -> pend_cnt=1, err=0. Then wr_en x3 alone -> pend_cnt=0.
REQ-041 sb_set x4 twice -> err=1 and pend_cnt=1. Then flush -> err=0 and pend_cnt=0; x4 contents unchanged.
REQ-042 Mark x1, x2, x9 pending, then pull reset_n low mid-cycle -> pend_cnt=0, err=0, and all reads 0 before the next edge.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: core-wide constants and helpers shared by the register file,
// its scoreboard and the bus interface.
//   XLEN_DEFAULT  default data width in bits
//   NREG_DEFAULT  default number of architectural registers (power of two, >= 2)
//   NRD_DEFAULT   default number of read ports (1..4)
//   addr_width()  register address width for a given register count
package regfile_sb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned NRD_DEFAULT  = 2;

    function automatic int unsigned addr_width(input int unsigned nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback, issue and status signals of the scoreboarded
// register file.
//   rd_addr  [NRD*AW]    packed read addresses, port k at [k*AW +: AW]
//   rd_data  [NRD*XLEN]  packed combinational read data
//   rd_busy  [NRD]       addressed register has a pending write
//   wr_en/wr_addr/wr_data  writeback strobe, register and value
//   sb_set/sb_addr       issue strobe marking a register pending
//   flush                synchronous clear of pending marks and err
//   pend_cnt [AW+1]      number of pending registers
//   err                  sticky WAW / orphan-writeback flag
// Modports: master drives requests (core / bench), slave is the register file.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned NRD  = NRD_DEFAULT
) ();
    localparam int unsigned AW = addr_width(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                flush;
    logic [AW:0]         pend_cnt;
    logic                err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush,
        input  rd_data, rd_busy, pend_cnt, err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush,
        output rd_data, rd_busy, pend_cnt, err
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-bit array, pending count and sticky error flag.
//   i_clock, i_reset_n      clock, asynchronous active-low reset
//   i_wr_en, i_wr_addr      writeback clears the pending mark
//   i_sb_set, i_sb_addr     issue sets the pending mark
//   i_flush                 clears all marks and err; issue is ignored
//   i_rd_addr               packed read addresses for busy lookup
//   o_rd_busy               per read port busy (same-cycle writeback unblocks)
//   o_pend_cnt              popcount of the pending bits
//   o_err                   sticky WAW / orphan-writeback flag
module regfile_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = 5
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic              i_sb_set,
    input  logic [AW-1:0]     i_sb_addr,
    input  logic              i_flush,
    input  logic [NRD*AW-1:0] i_rd_addr,
    output logic [NRD-1:0]    o_rd_busy,
    output logic [AW:0]       o_pend_cnt,
    output logic              o_err
);
    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0] r_pending;
    logic [AW:0]     r_pend_cnt;
    logic            r_err;

    logic [NREG-1:0] w_pending_d;
    logic [AW:0]     w_pend_cnt_d;
    logic            w_err_d;

    logic w_clr, w_set, w_same, w_inc, w_dec, w_waw, w_orphan;

    // x0 is never pending, so strobes aimed at it are dropped here.
    assign w_clr  = i_wr_en && (i_wr_addr != '0);
    assign w_set  = i_sb_set && (i_sb_addr != '0);
    assign w_same = (i_wr_addr == i_sb_addr);

    // Set wins over clear on the same register, so a clear only counts as a
    // 1->0 transition when no set hits that register.
    assign w_inc    = w_set && !r_pending[i_sb_addr];
    assign w_dec    = w_clr && r_pending[i_wr_addr] && !(w_set && w_same);
    assign w_waw    = w_set && r_pending[i_sb_addr] && !(w_clr && w_same);
    assign w_orphan = w_clr && !r_pending[i_wr_addr] && !(w_set && w_same);

    always_comb begin
        w_pending_d  = r_pending;
        w_pend_cnt_d = r_pend_cnt;
        w_err_d      = r_err;
        if (i_flush) begin
            w_pending_d  = '0;
            w_pend_cnt_d = '0;
            w_err_d      = 1'b0;
        end else begin
            if (w_clr) w_pending_d[i_wr_addr] = 1'b0;
            if (w_set) w_pending_d[i_sb_addr] = 1'b1;
            w_pend_cnt_d = r_pend_cnt + CW'(w_inc) - CW'(w_dec);
            w_err_d      = r_err | w_waw | w_orphan;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pending  <= w_pending_d;
            r_pend_cnt <= w_pend_cnt_d;
            r_err      <= w_err_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] w_ra;
        assign w_ra         = i_rd_addr[k*AW +: AW];
        assign o_rd_busy[k] = r_pending[w_ra] && !(i_wr_en && (i_wr_addr == w_ra));
    end

    assign o_pend_cnt = r_pend_cnt;
    assign o_err      = r_err;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through read bypass and a pending-write
// scoreboard. x0 reads as zero and ignores writes.
//   i_clock    system clock, rising edge
//   i_reset_n  asynchronous active-low reset (clears storage and scoreboard)
//   bus        regfile_sb_if slave: read ports, writeback, issue, flush, status
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned NRD  = NRD_DEFAULT
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    regfile_sb_if.slave  bus
);
    localparam int unsigned AW = addr_width(NREG);

    logic [XLEN-1:0]     r_regs [NREG];
    logic [NRD*XLEN-1:0] w_rd_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
        end else if (bus.wr_en && (bus.wr_addr != '0)) begin
            // Flush does not gate this: a writeback in a flush cycle still commits.
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = bus.rd_addr[k*AW +: AW];
        assign w_rd_data[k*XLEN +: XLEN] =
            (w_ra == '0)                             ? '0 :
            (bus.wr_en && (bus.wr_addr == w_ra))     ? bus.wr_data :
                                                       r_regs[w_ra];
    end

    assign bus.rd_data = w_rd_data;

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_sb_set   (bus.sb_set),
        .i_sb_addr  (bus.sb_addr),
        .i_flush    (bus.flush),
        .i_rd_addr  (bus.rd_addr),
        .o_rd_busy  (bus.rd_busy),
        .o_pend_cnt (bus.pend_cnt),
        .o_err      (bus.err)
    );

endmodule
